dmem_resp: RTL and testbench

Data-memory responder serving load/store requests from the core's memory-access stage over a valid/ready request channel and a valid/ready response channel. It sits on the memory side of the data interface. It implements RV32I load/store width, byte-lane and sign/zero-extension semantics. A fixed, parameterised access latency models slower memory, so the core's stall path is exercised.

---
 rtl/dmem_resp.sv | 162 ++++++++++++++++
 tb/tb_dmem_resp.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// RV32I data-memory responder: one load/store per request, fixed LATENCY, byte-lane stores and extended loads.
// Optional DMEM_RESP_STATS_EN adds saturating load/store/error counters.
module dmem_resp #(
    parameter logic [31:0] ADDR_BASE   = 32'h10010000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_RESP_STATS_EN
    ,
    output logic [15:0] ld_cnt,
    output logic [15:0] st_cnt,
    output logic [15:0] err_cnt
`endif
);
    localparam int IW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [2:0]  f3_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        acc, go;
    logic        c_we;
    logic [31:0] c_addr, c_wdata, off, word, ld_data, st_data;
    logic [2:0]  c_f3;
    logic [IW-1:0] idx;
    logic        oor, legal, mis, err;
    logic [7:0]  b;
    logic [15:0] h;
    logic [3:0]  be;

    assign req_ready = rst_n && (state == IDLE);
    assign acc       = req_valid && req_ready;
    // Commit happens on the edge that enters RESP; with LATENCY=1 that is the accept edge itself.
    assign go        = ((state == IDLE) && acc && (LATENCY == 1)) ||
                       ((state == WAIT) && (cnt == 4'd1));

    assign c_we    = (state == IDLE) ? req_we     : we_q;
    assign c_addr  = (state == IDLE) ? req_addr   : addr_q;
    assign c_f3    = (state == IDLE) ? req_funct3 : f3_q;
    assign c_wdata = (state == IDLE) ? req_wdata  : wdata_q;

    always_comb begin
        off   = c_addr - ADDR_BASE;
        oor   = off >= 32'(DEPTH_WORDS * 4);
        idx   = off[IW+1:2];
        legal = c_we ? (c_f3 == 3'd0 || c_f3 == 3'd1 || c_f3 == 3'd2)
                     : (c_f3 == 3'd0 || c_f3 == 3'd1 || c_f3 == 3'd2 ||
                        c_f3 == 3'd4 || c_f3 == 3'd5);
        mis   = ((c_f3[1:0] == 2'b01) && c_addr[0]) ||
                ((c_f3[1:0] == 2'b10) && (c_addr[1:0] != 2'b00));
        err   = oor || !legal || mis;
        word  = mem[idx];
        b     = word[{c_addr[1:0], 3'b000} +: 8];
        h     = c_addr[1] ? word[31:16] : word[15:0];
        case (c_f3)
            3'd0:    ld_data = {{24{b[7]}}, b};
            3'd1:    ld_data = {{16{h[15]}}, h};
            3'd2:    ld_data = word;
            3'd4:    ld_data = {24'd0, b};
            3'd5:    ld_data = {16'd0, h};
            default: ld_data = 32'd0;
        endcase
        case (c_f3[1:0])
            2'b00: begin
                be      = 4'b0001 << c_addr[1:0];
                st_data = {4{c_wdata[7:0]}};
            end
            2'b01: begin
                be      = c_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{c_wdata[15:0]}};
            end
            default: begin
                be      = 4'b1111;
                st_data = c_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (go && c_we && !err) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            f3_q      <= 3'd0;
            wdata_q   <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (acc) begin
                    we_q    <= req_we;
                    addr_q  <= req_addr;
                    f3_q    <= req_funct3;
                    wdata_q <= req_wdata;
                    cnt     <= 4'(LATENCY - 1);
                    state   <= (LATENCY == 1) ? RESP : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (go) state <= RESP;
                end
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (go) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= (err || c_we) ? 32'd0 : ld_data;
                rsp_err   <= err;
            end
        end
    end

`ifdef DMEM_RESP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt  <= 16'd0;
            st_cnt  <= 16'd0;
            err_cnt <= 16'd0;
        end else if (go) begin
            if (err) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end else if (c_we) begin
                if (st_cnt != 16'hFFFF) st_cnt <= st_cnt + 16'd1;
            end else begin
                if (ld_cnt != 16'hFFFF) ld_cnt <= ld_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboarded bench for dmem_resp: byte-array reference model, random stalls, directed
// RV32I width/extension/error cases, stall hold and mid-operation reset (second instance, LATENCY=3).
module tb_dmem_resp;
    localparam logic [31:0] BASE = 32'h10010000;
    localparam int LAT = 2;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        req_valid = 0, req_we = 0, rsp_ready = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [2:0]  req_funct3 = 0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        rst3_n = 0;
    logic        rv3 = 0, we3 = 0, rr3_in = 1;
    logic [31:0] a3 = 0, wd3 = 0;
    logic [2:0]  f3_3 = 0;
    logic        rdy3, rsv3, err3;
    logic [31:0] rd3;

`ifdef DMEM_RESP_STATS_EN
    logic [15:0] ld_cnt, st_cnt, err_cnt, ld3, st3, er3;
`endif

    dmem_resp #(.ADDR_BASE(BASE), .DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_RESP_STATS_EN
        , .ld_cnt(ld_cnt), .st_cnt(st_cnt), .err_cnt(err_cnt)
`endif
    );

    dmem_resp #(.ADDR_BASE(BASE), .DEPTH_WORDS(1024), .LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .req_valid(rv3), .req_ready(rdy3),
        .req_we(we3), .req_addr(a3), .req_funct3(f3_3), .req_wdata(wd3),
        .rsp_valid(rsv3), .rsp_ready(rr3_in), .rsp_rdata(rd3), .rsp_err(err3)
`ifdef DMEM_RESP_STATS_EN
        , .ld_cnt(ld3), .st_cnt(st3), .err_cnt(er3)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: memory as a flat byte array, rules applied directly from the ISA semantics.
    logic [7:0] rb [0:4095];
    task automatic model(input logic we, input logic [31:0] a, input logic [2:0] f,
                         input logic [31:0] wd, output logic [31:0] rd, output logic e);
        logic [31:0] off;
        int sz;
        logic legal;
        off   = a - BASE;
        legal = we ? (f <= 3'd2) : (f <= 3'd2 || f == 3'd4 || f == 3'd5);
        sz    = 1 << f[1:0];
        e     = !legal || (off >= 32'd4096) || ((int'(a[1:0]) % sz) != 0);
        rd    = 0;
        if (!e) begin
            if (we) begin
                for (int k = 0; k < sz; k++) rb[off + k] = wd[8*k +: 8];
            end else begin
                for (int k = 0; k < sz; k++) rd = rd | (32'(rb[off + k]) << (8*k));
                if (!f[2] && sz < 4 && rd[8*sz-1]) rd = rd | (32'hFFFFFFFF << (8*sz));
            end
        end
    endtask

    typedef struct { logic [31:0] rd; logic err; int at; } exp_t;
    exp_t q[$];

    // rsp_ready: 0 random, 1 held low, 2 held high
    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        rsp_ready = (rdy_mode == 1) ? 1'b0 : (rdy_mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: pop on first sight of each response, then require it to stay put until taken.
    logic        have = 0;
    logic [31:0] h_rd;
    logic        h_err;
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (!have) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rdata", rsp_rdata, e.rd);
                    chk("err", 32'(rsp_err), 32'(e.err));
                    chk("latency_cycle", cyc, e.at);
                    chk("req_ready_in_resp", 32'(req_ready), 32'd0);
                end
                h_rd = rsp_rdata; h_err = rsp_err; have = 1;
            end else begin
                chk("hold_rdata", rsp_rdata, h_rd);
                chk("hold_err", 32'(rsp_err), 32'(h_err));
            end
            if (rsp_ready) have = 0;
        end
    end

    // Drive a request (called just after a rising edge); expected result queued at acceptance.
    task automatic issue(input logic we, input logic [31:0] a, input logic [2:0] f, input logic [31:0] wd);
        exp_t e;
        int n;
        model(we, a, f, wd, e.rd, e.err);
        req_valid = 1; req_we = we; req_addr = a; req_funct3 = f; req_wdata = wd;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 32'd1, 32'd0);
                req_valid = 0;
                return;
            end
        end
        @(posedge clk); #1;
        req_valid = 0;
        // request presented after edge cyc-1 -> response visible after edge cyc-1+LAT
        e.at = cyc + LAT - 1;
        q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || have || rsp_valid) && n < 500) begin
            @(posedge clk); n++;
        end
        if (n >= 500) chk("drain_timeout", 32'd1, 32'd0);
        #1;
    endtask

    task automatic wait3(output logic ok);
        int n = 0;
        ok = 0;
        while (n < 30) begin
            @(negedge clk);
            if (rsv3) begin ok = 1; break; end
            n++;
        end
        if (!ok) chk("dut3_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        logic ok;
        // reset state
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        repeat (2) @(posedge clk);
        #1; rst_n = 1; rst3_n = 1;
        @(posedge clk); #1;

        // directed RV32I cases
        issue(1, 32'h10010004, 3'd2, 32'hDEADBEEF);
        issue(0, 32'h10010004, 3'd2, 0);
        issue(0, 32'h10010007, 3'd0, 0);
        issue(0, 32'h10010007, 3'd4, 0);
        issue(0, 32'h10010004, 3'd1, 0);
        issue(0, 32'h10010006, 3'd5, 0);
        issue(1, 32'h10010005, 3'd0, 32'h00000012);
        issue(0, 32'h10010004, 3'd2, 0);
        issue(1, 32'h10010006, 3'd1, 32'h0000ABCD);
        issue(0, 32'h10010004, 3'd2, 0);
        issue(1, 32'h10010000, 3'd2, 32'h01234567);
        issue(0, 32'h10010002, 3'd2, 0);
        issue(1, 32'h10011000, 3'd2, 32'hFFFFFFFF);
        issue(1, 32'h1000FFFC, 3'd2, 32'hFFFFFFFF);
        issue(0, 32'h10010000, 3'd2, 0);
        issue(0, 32'h10010000, 3'd3, 0);
        issue(1, 32'h10010000, 3'd4, 32'h0);
        issue(0, 32'h10010001, 3'd1, 0);
        issue(0, 32'h10010FFC, 3'd7, 0);
        drain();

        // stall: response must hold and block new requests, then release
        rdy_mode = 1;
        @(posedge clk); #1;
        issue(1, 32'h10010010, 3'd2, 32'hA5A5F00D);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = rsp_valid; end
        chk("stall_rsp_seen", 32'(ok), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
        end
        rdy_mode = 2;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("release_valid", 32'(rsp_valid), 32'd0);
        chk("release_req_ready", 32'(req_ready), 32'd1);
        rdy_mode = 0;
        @(posedge clk); #1;
        issue(0, 32'h10010010, 3'd2, 0);
        drain();

        // random traffic over a small window, preinitialised so every load is defined
        for (int w = 0; w < 16; w++) issue(1, BASE + 32'(4*w), 3'd2, $urandom);
        for (int i = 0; i < 150; i++) begin
            logic we;
            logic [2:0] f;
            logic [31:0] a;
            int r;
            we = $urandom_range(0, 1) == 1;
            r  = $urandom_range(0, 19);
            a  = BASE + 32'($urandom_range(0, 63));
            if (r == 0) a = BASE + 32'h1000 + 32'($urandom_range(0, 255));
            if (r == 1) a = BASE - 32'($urandom_range(1, 16));
            case ($urandom_range(0, 5))
                0: f = 3'd0;
                1: f = 3'd1;
                2: f = 3'd2;
                3: f = we ? 3'd0 : 3'd4;
                4: f = we ? 3'd1 : 3'd5;
                default: f = 3'($urandom_range(0, 7));
            endcase
            if (f[1:0] == 2'b10 && r > 4) a[1:0] = 2'b00;
            if (f[1:0] == 2'b01 && r > 4) a[0] = 1'b0;
            issue(we, a, f, $urandom);
        end
        drain();

        // mid-operation reset on the LATENCY=3 instance
        @(posedge clk); #1;
        rv3 = 1; we3 = 1; a3 = 32'h10010008; f3_3 = 3'd2; wd3 = 32'hCAFEF00D;
        @(posedge clk); #1; rv3 = 0;
        wait3(ok);
        @(posedge clk); #1;
        rv3 = 1; wd3 = 32'h00000055;
        @(negedge clk);
        chk("d3_ready", 32'(rdy3), 32'd1);
        @(posedge clk); #1; rv3 = 0;
        @(posedge clk); #1;
        rst3_n = 0;
        #1;
        chk("d3_rst_valid", 32'(rsv3), 32'd0);
        chk("d3_rst_ready", 32'(rdy3), 32'd0);
`ifdef DMEM_RESP_STATS_EN
        chk("d3_ld_cnt", 32'(ld3), 32'd0);
        chk("d3_st_cnt", 32'(st3), 32'd0);
        chk("d3_err_cnt", 32'(er3), 32'd0);
`endif
        @(posedge clk); #1; rst3_n = 1;
        @(posedge clk); #1;
        rv3 = 1; we3 = 0; f3_3 = 3'd2;
        @(posedge clk); #1; rv3 = 0;
        wait3(ok);
        chk("d3_old_value", rd3, 32'hCAFEF00D);
        chk("d3_old_err", 32'(err3), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule
